reg_writeback: RTL and testbench

Write-side front end for the 32x32 register file: collects ALU results and in-order load returns, queues them, and presents one register write per cycle on the file's write port (regwrite / alusrc / instdata / wdata). The register file decodes the destination from the instruction word itself (rt when alusrc=1, rd when alusrc=0), so this block forwards the instruction word and source flag with each result. It also keeps a pending-write scoreboard so issue logic can stall readers of registers with outstanding writes. It sits between the execute/memory stages and the register file.

---
 rtl/reg_writeback.sv | 164 ++++++++++++++++
 tb/tb_reg_writeback.sv | 243 ++++++++++++++++++++++++
 2 files changed

// File: rtl/reg_writeback.sv
// Write-side front end for the 32x32 register file. ALU results and load
// returns go into one write queue, and the queue drains one register write
// per cycle. A pending-write scoreboard covers outstanding loads, queued
// entries and the write currently on the port.
module reg_writeback #(
    parameter int QDEPTH = 4,
    parameter int LDEPTH = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        alu_valid,
    output logic        alu_ready,
    input  logic [31:0] alu_inst,
    input  logic        alu_alusrc,
    input  logic [31:0] alu_result,
    input  logic        ld_issue,
    output logic        ld_issue_ready,
    input  logic [31:0] ld_inst,
    input  logic        ld_valid,
    output logic        ld_ready,
    input  logic [31:0] ld_data,
    input  logic        wb_hold,
    output logic        regwrite,
    output logic        alusrc,
    output logic [31:0] instdata,
    output logic [31:0] wdata,
    output logic [31:0] pending,
    output logic        ld_err
);
    localparam int QA = $clog2(QDEPTH);
    localparam int LA = $clog2(LDEPTH);

    // The register file picks rt when alusrc=1 and rd when alusrc=0.
    function automatic logic [4:0] dest_of(input logic src, input logic [31:0] inst);
        return src ? inst[20:16] : inst[15:11];
    endfunction

    logic          q_src  [QDEPTH];
    logic [31:0]   q_inst [QDEPTH];
    logic [31:0]   q_data [QDEPTH];
    logic [QA-1:0] q_rd, q_wr;
    logic [QA:0]   q_cnt;

    logic [31:0]   t_inst [LDEPTH];
    logic [LA-1:0] t_rd, t_wr;
    logic [LA:0]   t_cnt;

    logic        q_full, t_empty, t_full;
    logic        ld_acc, alu_acc, tag_push, push_en, pop_en;
    logic        push_src;
    logic [31:0] push_inst, push_data;
    logic [31:0] pend;

    assign q_full  = (q_cnt == (QA+1)'(QDEPTH));
    assign t_empty = (t_cnt == '0);
    assign t_full  = (t_cnt == (LA+1)'(LDEPTH));

    assign ld_issue_ready = !t_full;
    assign ld_ready       = !q_full && !t_empty;
    assign alu_ready      = !q_full && !(ld_valid && ld_ready);
    assign ld_acc         = ld_valid && ld_ready;
    assign alu_acc        = alu_valid && alu_ready;
    assign tag_push       = ld_issue && ld_issue_ready;
    assign pop_en         = (q_cnt != '0) && !wb_hold;

    // Select the entry to enqueue; load returns win over ALU results, and
    // writes to register 0 are consumed without being queued.
    always_comb begin
        push_src  = 1'b0;
        push_inst = '0;
        push_data = '0;
        if (ld_acc) begin
            push_src  = 1'b1;
            push_inst = t_inst[t_rd];
            push_data = ld_data;
        end else if (alu_acc) begin
            push_src  = alu_alusrc;
            push_inst = alu_inst;
            push_data = alu_result;
        end
        push_en = (ld_acc || alu_acc) && (dest_of(push_src, push_inst) != 5'd0);
    end

    // Write queue storage; contents need no reset since the count gates validity.
    always_ff @(posedge clk) begin
        if (push_en) begin
            q_src[q_wr]  <= push_src;
            q_inst[q_wr] <= push_inst;
            q_data[q_wr] <= push_data;
        end
    end

    // Write queue pointers and occupancy.
    always_ff @(posedge clk) begin
        if (rst) begin
            q_rd  <= '0;
            q_wr  <= '0;
            q_cnt <= '0;
        end else begin
            if (push_en) q_wr <= q_wr + 1'b1;
            if (pop_en)  q_rd <= q_rd + 1'b1;
            if (push_en && !pop_en)      q_cnt <= q_cnt + 1'b1;
            else if (!push_en && pop_en) q_cnt <= q_cnt - 1'b1;
        end
    end

    // Load tag FIFO storage, holding the instruction words of issued loads.
    always_ff @(posedge clk) begin
        if (tag_push) t_inst[t_wr] <= ld_inst;
    end

    // Load tag FIFO pointers and occupancy.
    always_ff @(posedge clk) begin
        if (rst) begin
            t_rd  <= '0;
            t_wr  <= '0;
            t_cnt <= '0;
        end else begin
            if (tag_push) t_wr <= t_wr + 1'b1;
            if (ld_acc)   t_rd <= t_rd + 1'b1;
            if (tag_push && !ld_acc)      t_cnt <= t_cnt + 1'b1;
            else if (!tag_push && ld_acc) t_cnt <= t_cnt - 1'b1;
        end
    end

    // Write port register; the payload holds its last value when idle.
    always_ff @(posedge clk) begin
        if (rst) begin
            regwrite <= 1'b0;
            alusrc   <= 1'b0;
            instdata <= '0;
            wdata    <= '0;
        end else if (pop_en) begin
            regwrite <= 1'b1;
            alusrc   <= q_src[q_rd];
            instdata <= q_inst[q_rd];
            wdata    <= q_data[q_rd];
        end else begin
            regwrite <= 1'b0;
        end
    end

    // A load return with no outstanding load is a protocol error; stays set.
    always_ff @(posedge clk) begin
        if (rst)                       ld_err <= 1'b0;
        else if (ld_valid && t_empty)  ld_err <= 1'b1;
    end

    // Scoreboard: mark every register with an outstanding, queued or in-flight write.
    always_comb begin
        pend = '0;
        for (int j = 0; j < LDEPTH; j++) begin
            if ({1'b0, LA'(j) - t_rd} < t_cnt) pend[t_inst[j][20:16]] = 1'b1;
        end
        for (int j = 0; j < QDEPTH; j++) begin
            if ({1'b0, QA'(j) - q_rd} < q_cnt) pend[dest_of(q_src[j], q_inst[j])] = 1'b1;
        end
        if (regwrite) pend[dest_of(alusrc, instdata)] = 1'b1;
        pend[0] = 1'b0;
    end

    assign pending = pend;

endmodule

// File: tb/tb_reg_writeback.sv
// Directed bench for reg_writeback with a queue-level reference model.
module tb_reg_writeback;
    localparam int QDEPTH = 4;
    localparam int LDEPTH = 4;

    logic        clk = 1'b0;
    logic        rst;
    logic        alu_valid, alu_alusrc, ld_issue, ld_valid, wb_hold;
    logic [31:0] alu_inst, alu_result, ld_inst, ld_data;
    logic        alu_ready, ld_issue_ready, ld_ready, regwrite, alusrc, ld_err;
    logic [31:0] instdata, wdata, pending;

    int checks = 0;
    int failures = 0;

    reg_writeback #(.QDEPTH(QDEPTH), .LDEPTH(LDEPTH)) dut (
        .clk(clk), .rst(rst),
        .alu_valid(alu_valid), .alu_ready(alu_ready), .alu_inst(alu_inst),
        .alu_alusrc(alu_alusrc), .alu_result(alu_result),
        .ld_issue(ld_issue), .ld_issue_ready(ld_issue_ready), .ld_inst(ld_inst),
        .ld_valid(ld_valid), .ld_ready(ld_ready), .ld_data(ld_data),
        .wb_hold(wb_hold),
        .regwrite(regwrite), .alusrc(alusrc), .instdata(instdata), .wdata(wdata),
        .pending(pending), .ld_err(ld_err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h expected=%h at %0t", nm, act, exp, $time);
        end
    endtask

    function automatic logic [4:0] dst(input logic a, input logic [31:0] i);
        return a ? i[20:16] : i[15:11];
    endfunction

    // Reference model: a write queue and a tag queue as plain SV queues.
    typedef struct packed {
        logic        a;
        logic [31:0] i;
        logic [31:0] d;
    } ent_t;

    ent_t        mq[$];
    logic [31:0] mt[$];
    logic        m_rw, m_src, m_err, started;
    logic [31:0] m_inst, m_data;
    bit          m_lrdy, m_ardy, m_pop, m_has;
    ent_t        m_ent;

    initial started = 1'b0;

    always @(posedge clk) begin
        if (rst) begin
            mq.delete();
            mt.delete();
            m_rw = 0; m_src = 0; m_inst = 0; m_data = 0; m_err = 0;
            started = 1'b1;
        end else if (started) begin
            m_lrdy = (mq.size() < QDEPTH) && (mt.size() > 0);
            m_ardy = (mq.size() < QDEPTH) && !(ld_valid && m_lrdy);
            m_pop  = (mq.size() > 0) && !wb_hold;
            m_has  = 0;
            if (ld_valid && mt.size() == 0) m_err = 1;
            if (ld_valid && m_lrdy) begin
                m_ent = '{a: 1'b1, i: mt[0], d: ld_data};
                m_has = 1;
            end else if (alu_valid && m_ardy) begin
                m_ent = '{a: alu_alusrc, i: alu_inst, d: alu_result};
                m_has = 1;
            end
            if (ld_issue && mt.size() < LDEPTH) mt.push_back(ld_inst);
            if (ld_valid && m_lrdy) void'(mt.pop_front());
            if (m_pop) begin
                m_rw = 1; m_src = mq[0].a; m_inst = mq[0].i; m_data = mq[0].d;
                void'(mq.pop_front());
            end else begin
                m_rw = 0;
            end
            if (m_has && dst(m_ent.a, m_ent.i) != 5'd0) mq.push_back(m_ent);
        end
    end

    // Compare every output against the model on the falling edge.
    always @(negedge clk) begin
        logic [31:0] ep;
        bit lr, ar;
        if (started) begin
            lr = (mq.size() < QDEPTH) && (mt.size() > 0);
            ar = (mq.size() < QDEPTH) && !(ld_valid && lr);
            ep = '0;
            foreach (mt[k]) ep[mt[k][20:16]] = 1'b1;
            foreach (mq[k]) ep[dst(mq[k].a, mq[k].i)] = 1'b1;
            if (m_rw) ep[dst(m_src, m_inst)] = 1'b1;
            ep[0] = 1'b0;
            chk("m_regwrite", {31'b0, regwrite}, {31'b0, m_rw});
            chk("m_alusrc", {31'b0, alusrc}, {31'b0, m_src});
            chk("m_instdata", instdata, m_inst);
            chk("m_wdata", wdata, m_data);
            chk("m_ld_ready", {31'b0, ld_ready}, {31'b0, lr});
            chk("m_alu_ready", {31'b0, alu_ready}, {31'b0, ar});
            chk("m_issue_ready", {31'b0, ld_issue_ready}, {31'b0, mt.size() < LDEPTH});
            chk("m_ld_err", {31'b0, ld_err}, {31'b0, m_err});
            chk("m_pending", pending, ep);
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst = 1; alu_valid = 0; alu_alusrc = 0; alu_inst = 0; alu_result = 0;
        ld_issue = 0; ld_inst = 0; ld_valid = 0; ld_data = 0; wb_hold = 0;
        tick(); tick();
        rst = 0;
        chk("rst_regwrite", {31'b0, regwrite}, 32'd0);
        chk("rst_wdata", wdata, 32'd0);
        chk("rst_pending", pending, 32'd0);

        // ALU write to rd=5
        alu_valid = 1; alu_alusrc = 0; alu_inst = 32'h0000_2800; alu_result = 32'h1234;
        tick();
        alu_valid = 0;
        chk("t1_pend_queued", {31'b0, pending[5]}, 32'd1);
        chk("t1_rw_early", {31'b0, regwrite}, 32'd0);
        tick();
        chk("t1_rw", {31'b0, regwrite}, 32'd1);
        chk("t1_wdata", wdata, 32'h1234);
        chk("t1_rd", {27'b0, instdata[15:11]}, 32'd5);
        chk("t1_pend_out", {31'b0, pending[5]}, 32'd1);
        tick();
        chk("t1_rw_done", {31'b0, regwrite}, 32'd0);
        chk("t1_pend_clr", {31'b0, pending[5]}, 32'd0);

        // load rt=7 returning together with an ALU result
        ld_issue = 1; ld_inst = 32'h8C07_0000;
        tick();
        ld_issue = 0;
        chk("t2_pend7", pending, 32'h0000_0080);
        tick();
        ld_valid = 1; ld_data = 32'hDEAD_BEEF;
        alu_valid = 1; alu_alusrc = 0; alu_inst = 32'h0000_4800; alu_result = 32'h99;
        #1;
        chk("t2_alu_blocked", {31'b0, alu_ready}, 32'd0);
        chk("t2_ld_ready", {31'b0, ld_ready}, 32'd1);
        tick();
        ld_valid = 0;
        tick();
        alu_valid = 0;
        chk("t2_ld_wdata", wdata, 32'hDEAD_BEEF);
        chk("t2_ld_src", {31'b0, alusrc}, 32'd1);
        chk("t2_ld_rt", {27'b0, instdata[20:16]}, 32'd7);
        tick();
        chk("t2_alu_wdata", wdata, 32'h99);
        chk("t2_alu_src", {31'b0, alusrc}, 32'd0);
        tick();

        // hold with five ALU offers; fourth fills the queue
        wb_hold = 1;
        for (int i = 1; i <= 5; i++) begin
            alu_valid = 1; alu_alusrc = 0; alu_inst = 32'(i) << 11; alu_result = 32'hA0 + 32'(i);
            #1;
            if (i == 5) chk("t3_full", {31'b0, alu_ready}, 32'd0);
            tick();
        end
        alu_valid = 0; wb_hold = 0;
        for (int k = 0; k < 4; k++) begin
            tick();
            chk("t3_order", wdata, 32'hA1 + 32'(k));
        end
        tick();

        // full queue released while ALU keeps offering
        wb_hold = 1;
        for (int i = 0; i < 12; i++) begin
            if (i == 5) wb_hold = 0;
            alu_valid = 1; alu_alusrc = i[0]; alu_result = 32'h500 + 32'(i);
            alu_inst = i[0] ? (32'(i + 1) << 16) : (32'(i + 1) << 11);
            tick();
        end
        alu_valid = 0;
        repeat (6) tick();

        // destination 0 from both paths
        alu_valid = 1; alu_alusrc = 0; alu_inst = 32'h0000_0000; alu_result = 32'h55;
        ld_issue = 1; ld_inst = 32'h8C00_0000;
        #1;
        chk("t4_alu_rdy", {31'b0, alu_ready}, 32'd1);
        tick();
        alu_valid = 0; ld_issue = 0;
        ld_valid = 1; ld_data = 32'h77;
        #1;
        chk("t4_ld_rdy", {31'b0, ld_ready}, 32'd1);
        tick();
        ld_valid = 0;
        repeat (3) begin
            tick();
            chk("t4_no_write", {31'b0, regwrite}, 32'd0);
        end
        chk("t4_pend", pending, 32'd0);

        // spurious load return
        ld_valid = 1; ld_data = 32'h1;
        #1;
        chk("t5_ld_ready", {31'b0, ld_ready}, 32'd0);
        tick();
        ld_valid = 0;
        chk("t5_err", {31'b0, ld_err}, 32'd1);
        tick();
        chk("t5_sticky", {31'b0, ld_err}, 32'd1);
        rst = 1;
        tick();
        rst = 0;
        chk("t5_err_clr", {31'b0, ld_err}, 32'd0);

        // reset with loads outstanding
        for (int k = 0; k < 3; k++) begin
            ld_issue = 1; ld_inst = 32'h8C00_0000 | (32'(10 + k) << 16);
            tick();
        end
        ld_issue = 0;
        chk("t6_pend", pending, 32'h0000_1C00);
        rst = 1;
        tick();
        rst = 0;
        chk("t6_pend_rst", pending, 32'd0);
        ld_valid = 1; ld_data = 32'h3;
        tick();
        ld_valid = 0;
        chk("t6_err", {31'b0, ld_err}, 32'd1);
        chk("t6_no_write", {31'b0, regwrite}, 32'd0);
        repeat (2) tick();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
